// File: rtl/sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller:
// FSM state encoding and the supported operand width ceiling.
package sub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_subtractor_ctrl_cell.sv
// Single-bit subtractor cell: two half subtractors whose borrows are ORed.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bo
);
    assign d  = a ^ b;
    assign bo = ~a & b;
endmodule

module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);
    logic d1;
    logic bo1;
    logic bo2;

    half_subtractor u_hs0 (.a(a),  .b(b),   .d(d1), .bo(bo1));
    half_subtractor u_hs1 (.a(d1), .b(bin), .d(d),  .bo(bo2));

    assign bo = bo1 | bo2;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B - bin controller: one subtractor cell reused LSB first
// over WIDTH cycles, with a start/done handshake and held parallel result.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | ready for start; last diff/borrow held
//   RUN     | one operand bit per edge through the shared cell
//   DONE    | one-cycle done pulse, result valid; back to IDLE next
module serial_subtractor_ctrl
    import sub_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic               bor;
    logic [CNT_W-1:0]   cnt;
    logic               cell_d;
    logic               cell_bo;

    full_subtractor_cell u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .bin (bor),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST_BIT) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result bits enter at the MSB so the LSB-first stream lands in place
    // after exactly WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            bor    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        b_sh <= b;
                        bor  <= bin;
                        cnt  <= '0;
                        diff <= '0;
                    end
                end
                ST_RUN: begin
                    diff <= {cell_d, diff[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    bor  <= cell_bo;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        borrow <= cell_bo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_RUN);
    assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Randomized self-checking bench for serial_subtractor_ctrl at WIDTH=8 and
// WIDTH=16 against a plain-arithmetic subtraction model.
module tb_serial_subtractor_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start_v = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [1:0]  bin_v = 2'b00;
    logic [1:0]  ready_v, busy_v, done_v, borrow_v;
    logic [7:0]  diff8;
    logic [15:0] diff16;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a8), .b(b8), .bin(bin_v[0]),
        .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .diff(diff8), .borrow(borrow_v[0])
    );

    serial_subtractor_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a16), .b(b16), .bin(bin_v[1]),
        .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .diff(diff16), .borrow(borrow_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] diff_of(input int u);
        return (u == 0) ? 32'(diff8) : 32'(diff16);
    endfunction

    function automatic logic [31:0] exp_diff(input int w, input logic [31:0] av, bv, input logic bi);
        longint m = (64'd1 << w) - 1;
        return 32'((longint'(av) - longint'(bv) - longint'(bi)) & m);
    endfunction

    function automatic logic exp_borrow(input logic [31:0] av, bv, input logic bi);
        return longint'(av) < (longint'(bv) + longint'(bi));
    endfunction

    task automatic drive_ops(input int u, input logic [31:0] av, bv, input logic bi);
        if (u == 0) begin a8 = av[7:0]; b8 = bv[7:0]; end
        else begin a16 = av[15:0]; b16 = bv[15:0]; end
        bin_v[u] = bi;
    endtask

    // One full operation: start pulse, scramble inputs during RUN, check
    // busy length, done latency, result and the hold after done.
    task automatic run_op(input int u, input logic [31:0] av, bv, input logic bi);
        int w = (u == 0) ? 8 : 16;
        int busy_n = 0;
        int lat = -1;
        logic [31:0] ed = exp_diff(w, av, bv, bi);
        logic eb = exp_borrow(av, bv, bi);
        @(negedge clk);
        drive_ops(u, av, bv, bi);
        start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        drive_ops(u, $urandom, $urandom, 1'($urandom));
        for (int j = 0; j < 4 * w && lat < 0; j++) begin
            if (j > 0) @(negedge clk);
            if (done_v[u]) lat = j;
            else if (busy_v[u]) busy_n++;
        end
        if (lat < 0) begin
            chk("done_timeout", 32'(lat), 32'(w));
            return;
        end
        chk("latency", 32'(lat), 32'(w));
        chk("busy_cycles", 32'(busy_n), 32'(w));
        chk("diff", diff_of(u), ed);
        chk("borrow", 32'(borrow_v[u]), 32'(eb));
        chk("ready_in_done", 32'(ready_v[u]), 32'd0);
        @(negedge clk);
        chk("ready_after", 32'(ready_v[u]), 32'd1);
        chk("done_single", 32'(done_v[u]), 32'd0);
        chk("diff_held", diff_of(u), ed);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dpos[$];
        logic [31:0] dval[$];
        logic bval[$];
        int extra;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_v), 32'h3);
        chk("rst_busy", 32'(busy_v), 32'h0);
        chk("rst_done", 32'(done_v), 32'h0);
        chk("rst_diff8", 32'(diff8), 32'h0);
        chk("rst_borrow", 32'(borrow_v), 32'h0);
        rst_n = 1'b1;

        run_op(0, 32'h5A, 32'h3C, 1'b0);
        run_op(0, 32'h10, 32'h20, 1'b0);
        run_op(0, 32'h00, 32'h00, 1'b1);
        run_op(0, 32'hFF, 32'hFF, 1'b0);

        // start held high through RUN with changed operands
        @(negedge clk);
        drive_ops(0, 32'h5A, 32'h3C, 1'b0);
        start_v[0] = 1'b1;
        @(negedge clk);
        drive_ops(0, 32'h10, 32'h20, 1'b0);
        for (int j = 0; j < 20; j++) begin
            if (j > 0) @(negedge clk);
            if (done_v[0]) begin
                dpos.push_back(j);
                dval.push_back(32'(diff8));
                bval.push_back(borrow_v[0]);
            end
            if (j == 19) start_v[0] = 1'b0;
        end
        chk("hold_done_count", 32'(dpos.size()), 32'd2);
        if (dpos.size() == 2) begin
            chk("hold_first_pos", 32'(dpos[0]), 32'd8);
            chk("hold_spacing", 32'(dpos[1] - dpos[0]), 32'd10);
            chk("hold_first_diff", dval[0], 32'h1E);
            chk("hold_first_borrow", 32'(bval[0]), 32'd0);
            chk("hold_second_diff", dval[1], 32'hF0);
            chk("hold_second_borrow", 32'(bval[1]), 32'd1);
        end
        extra = 0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) extra++;
        end
        chk("hold_no_third_op", 32'(extra), 32'd0);

        // reset during cycle 4 of RUN, after a borrow=1 result is held
        run_op(0, 32'h00, 32'h01, 1'b0);
        @(negedge clk);
        drive_ops(0, 32'h5A, 32'h3C, 1'b0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(ready_v[0]), 32'd1);
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_done", 32'(done_v[0]), 32'd0);
        chk("midrst_diff", 32'(diff8), 32'd0);
        chk("midrst_borrow", 32'(borrow_v[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (done_v[0]) extra++;
        end
        chk("midrst_no_done", 32'(extra), 32'd0);
        run_op(0, 32'hC3, 32'h4D, 1'b1);

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 1000; i++) begin
                logic [31:0] av = $urandom;
                logic [31:0] bv = $urandom;
                int sel = int'($urandom_range(0, 9));
                if (u == 0) begin av &= 32'hFF; bv &= 32'hFF; end
                else begin av &= 32'hFFFF; bv &= 32'hFFFF; end
                if (sel == 0) av = 0;
                if (sel == 1) bv = (u == 0) ? 32'hFF : 32'hFFFF;
                if (sel == 2) bv = av;
                run_op(u, av, bv, 1'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial N-bit subtractor controller. It time-shares one single-bit subtractor cell across all operand bits, LSB first, and computes A - B - bin over WIDTH clock cycles. It provides a start/done handshake for the upstream arithmetic sequencer and presents the parallel difference plus the final borrow.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only while ready=1
a  input  WIDTH  minuend; captured on an accepted start
b  input  WIDTH  subtrahend; captured on an accepted start
bin  input  1  borrow-in; captured on an accepted start
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  single-cycle pulse, high in DONE
diff  output  WIDTH  difference; held stable from DONE until the next accepted start
borrow  output  1  final borrow-out (1 = underflow); held like diff

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, busy=0, done=0, diff=0, borrow=0, counter=0, internal a_sh/b_sh/bor=0.
- States: IDLE, RUN, DONE; encoding 2'b00/01/10; 2'b11 is illegal and goes to IDLE.
- IDLE, start=1 at edge E0: a_sh<=a, b_sh<=b, bor<=bin, cnt<=0, diff<=0, state<=RUN. With start=0, stay in IDLE and leave outputs unchanged.
- RUN, each edge:
  - Cell inputs are a_sh[0], b_sh[0], bor.
  - d = a_sh[0]^b_sh[0]^bor.
  - bo = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bor).
  - diff <= {d, diff[WIDTH-1:1]}; a_sh and b_sh shift right by 1; bor<=bo; cnt<=cnt+1.
- RUN exit: on the edge where cnt==WIDTH-1, process the last bit, borrow<=bo, state<=DONE.
- RUN duration: exactly WIDTH edges (E1..E_WIDTH).
- DONE: done=1 for exactly one cycle. The next edge goes to IDLE unconditionally.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH+1 cycles after the start sample. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy or done is ignored, with no queueing. a/b/bin changes during RUN have no effect.
- Arithmetic: unsigned modulo 2^WIDTH. borrow=1 iff a < b+bin (unsigned).
- diff/borrow may update mid-operation during RUN (shift in progress). They are only valid while done=1 and afterwards in IDLE.
- Reset asserted mid-RUN returns immediately to the reset values. No done pulse is issued and there is no partial result.
- Outputs are registered; no combinational path from inputs to outputs except through state.

Decomposition:
- Shared package sub_ctrl_pkg holds the state localparams (ST_IDLE, ST_RUN, ST_DONE) and WIDTH_MAX=32.
- Sub-module full_subtractor_cell (a, b, bin -> d, bo) is built from two half_subtractor instances plus an OR of their borrows. It is instantiated once; the controller contains no other arithmetic.

Test Plan:
1. a=8'h5A, b=8'h3C, bin=0, start pulse -> busy high 8 cycles; done pulse at cycle 9; diff=8'h1E, borrow=0.
2. a=8'h10, b=8'h20, bin=0 -> diff=8'hF0, borrow=1.
3. a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, borrow=1. Also a=8'hFF, b=8'hFF, bin=0 -> diff=8'h00, borrow=0.
4. start=1 held continuously during RUN with different a/b -> the first result is unaffected, exactly one done pulse, and a new operation starts only from IDLE. Spacing is 10 cycles for WIDTH=8.
5. rst_n low at cycle 4 of RUN -> ready=1, busy=0, done=0, diff=0, borrow=0 immediately; no done pulse follows. The next start then gives a correct result.
6. Random sweep, WIDTH=8 and WIDTH=16, 1000 ops: diff=={a-b-bin} and borrow==(a<b+bin) on every done.
